// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: GPIO window base address and register word indices
package gpio_ctrl_pkg;
    localparam logic [31:0] GPIO_BASE_ADDR = 32'h4000_0000;

    typedef enum logic [3:0] {
        GPIO_REG_OUT     = 4'd0,
        GPIO_REG_DIR     = 4'd1,
        GPIO_REG_IN      = 4'd2,
        GPIO_REG_SET     = 4'd3,
        GPIO_REG_CLR     = 4'd4,
        GPIO_REG_TGL     = 4'd5,
        GPIO_REG_RISE_EN = 4'd6,
        GPIO_REG_FALL_EN = 4'd7,
        GPIO_REG_STAT    = 4'd8
    } gpio_reg_e;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH x STAGES flop-chain synchroniser for asynchronous pin inputs
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with direction, atomic set/clear/toggle,
// synchronised input readback and sticky edge interrupts
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    logic [WIDTH-1:0] wd, in_s, prev_q, out_q, dir_q, ren_q, fen_q, stat_q;
    logic [WIDTH-1:0] out_n, evt, w1c;
    logic [31:0]      rd_n;
    logic             unused_wr;

    assign wd        = wr_data[WIDTH-1:0];
    assign unused_wr = ^wr_data;

    gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_i),
        .q   (in_s)
    );

    assign evt   = (in_s & ~prev_q & ren_q) | (~in_s & prev_q & fen_q);
    assign w1c   = (we && addr == GPIO_REG_STAT) ? wd : '0;
    assign out_n = !we                    ? out_q :
                   addr == GPIO_REG_OUT   ? wd :
                   addr == GPIO_REG_SET   ? out_q | wd :
                   addr == GPIO_REG_CLR   ? out_q & ~wd :
                   addr == GPIO_REG_TGL   ? out_q ^ wd : out_q;

    // Read mux samples pre-write state so a same-cycle write returns the old value
    always_comb begin
        rd_n = '0;
        case (addr)
            GPIO_REG_OUT:     rd_n[WIDTH-1:0] = out_q;
            GPIO_REG_DIR:     rd_n[WIDTH-1:0] = dir_q;
            GPIO_REG_IN:      rd_n[WIDTH-1:0] = in_s;
            GPIO_REG_RISE_EN: rd_n[WIDTH-1:0] = ren_q;
            GPIO_REG_FALL_EN: rd_n[WIDTH-1:0] = fen_q;
            GPIO_REG_STAT:    rd_n[WIDTH-1:0] = stat_q;
            default:          rd_n = '0;
        endcase
        if (!re) rd_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= OUT_RESET;
            dir_q   <= DIR_RESET;
            ren_q   <= '0;
            fen_q   <= '0;
            stat_q  <= '0;
            prev_q  <= '0;
            rd_data <= '0;
        end else begin
            out_q   <= out_n;
            dir_q   <= (we && addr == GPIO_REG_DIR) ? wd : dir_q;
            ren_q   <= (we && addr == GPIO_REG_RISE_EN) ? wd : ren_q;
            fen_q   <= (we && addr == GPIO_REG_FALL_EN) ? wd : fen_q;
            stat_q  <= (stat_q & ~w1c) | evt;
            prev_q  <= in_s;
            rd_data <= rd_n;
        end
    end

    assign irq     = |stat_q;
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed scenarios plus randomized traffic checked against a
// register-level reference model of the GPIO window
module tb_gpio_ctrl;
    localparam int S = 2;

    logic        clk = 0;
    logic        rst = 0;
    logic        we = 0, re = 0;
    logic [3:0]  addr = 0;
    logic [31:0] wr_data = 0;
    logic [31:0] rd_data;
    logic [7:0]  gpio_i = 0, gpio_o, gpio_oe;
    logic        irq;

    logic        we4 = 0, re4 = 0;
    logic [3:0]  addr4 = 0;
    logic [31:0] wd4 = 0, rd4;
    logic [3:0]  gi4 = 0, o4, oe4;
    logic        irq4;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  m_out, m_dir, m_ren, m_fen, m_stat;
    logic [7:0]  smp [0:S];
    logic [31:0] m_rd;

    always #5 clk = ~clk;

    gpio_ctrl dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .we(we4), .re(re4), .addr(addr4), .wr_data(wd4),
        .rd_data(rd4), .gpio_i(gi4), .gpio_o(o4), .gpio_oe(oe4), .irq(irq4)
    );

    function automatic logic [31:0] m_read(input logic [3:0] a, input logic [7:0] pin);
        case (a)
            4'd0: return {24'b0, m_out};
            4'd1: return {24'b0, m_dir};
            4'd2: return {24'b0, pin};
            4'd6: return {24'b0, m_ren};
            4'd7: return {24'b0, m_fen};
            4'd8: return {24'b0, m_stat};
            default: return 32'b0;
        endcase
    endfunction

    // One clock edge; the model consumes the inputs presented before the edge.
    // smp[k] is the pin value sampled k edges ago, so IN is the pin S edges old.
    task automatic tick();
        logic [7:0]  pin, prv, evt, w1c, d;
        logic [31:0] r;
        pin = smp[S-1];
        prv = smp[S];
        d   = wr_data[7:0];
        r   = re ? m_read(addr, pin) : 32'b0;
        w1c = (we && addr == 4'd8) ? d : 8'h00;
        evt = (pin & ~prv & m_ren) | (~pin & prv & m_fen);
        @(posedge clk);
        #1;
        if (rst) begin
            m_out = 8'h00; m_dir = 8'hFF; m_ren = 0; m_fen = 0; m_stat = 0; m_rd = 0;
            for (int i = 0; i <= S; i++) smp[i] = 0;
        end else begin
            m_rd   = r;
            m_stat = (m_stat & ~w1c) | evt;
            if (we) begin
                case (addr)
                    4'd0: m_out = d;
                    4'd1: m_dir = d;
                    4'd3: m_out = m_out | d;
                    4'd4: m_out = m_out & ~d;
                    4'd5: m_out = m_out ^ d;
                    4'd6: m_ren = d;
                    4'd7: m_fen = d;
                    default: ;
                endcase
            end
            for (int i = S; i > 0; i--) smp[i] = smp[i-1];
            smp[0] = gpio_i;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = a; wr_data = d; we = 1;
        tick();
        we = 0;
    endtask

    task automatic rd(input logic [3:0] a);
        addr = a; re = 1;
        tick();
        re = 0;
    endtask

    task automatic test_reset();
        rst = 1; we = 1; addr = 0; wr_data = 32'hFF;
        we4 = 1; addr4 = 0; wd4 = 32'hFF;
        tick(); tick();
        rst = 0; we = 0; we4 = 0;
        vectors++; if (gpio_o !== 8'h00) begin miscompares++; $display("FAIL reset_out: got %h want 00", gpio_o); end
        vectors++; if (gpio_oe !== 8'hFF) begin miscompares++; $display("FAIL reset_dir: got %h want ff", gpio_oe); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd: got %h want 0", rd_data); end
        vectors++; if (o4 !== 4'h0 || oe4 !== 4'hF) begin miscompares++; $display("FAIL reset_w4: got %h/%h want 0/f", o4, oe4); end
        rd(4'd8);
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_stat: got %h want 0", rd_data); end
    endtask

    task automatic test_atomic();
        wr(4'd0, 32'h0F);
        vectors++; if (gpio_o !== 8'h0F) begin miscompares++; $display("FAIL out_wr: got %h want 0f", gpio_o); end
        wr(4'd3, 32'h30);
        vectors++; if (gpio_o !== 8'h3F) begin miscompares++; $display("FAIL set: got %h want 3f", gpio_o); end
        wr(4'd4, 32'h03);
        vectors++; if (gpio_o !== 8'h3C) begin miscompares++; $display("FAIL clr: got %h want 3c", gpio_o); end
        wr(4'd5, 32'hFF);
        vectors++; if (gpio_o !== 8'hC3) begin miscompares++; $display("FAIL tgl: got %h want c3", gpio_o); end
        rd(4'd3);
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL set_read: got %h want 0", rd_data); end
        rd(4'd0);
        vectors++; if (rd_data !== 32'hC3) begin miscompares++; $display("FAIL out_read: got %h want c3", rd_data); end
    endtask

    task automatic test_input_latency();
        gpio_i = 8'h05; addr = 4'd2; re = 1;
        tick(); tick();
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL in_early: got %h want 0", rd_data); end
        tick();
        re = 0;
        vectors++; if (rd_data !== 32'h05) begin miscompares++; $display("FAIL in_latency: got %h want 05", rd_data); end
    endtask

    task automatic test_edge_irq();
        gpio_i = 8'h00;
        repeat (4) tick();
        wr(4'd6, 32'h01);
        wr(4'd7, 32'h02);
        gpio_i = 8'h01;
        tick(); tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b want 0", irq); end
        tick();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise: got %b want 1", irq); end
        gpio_i = 8'h03;
        repeat (4) tick();
        gpio_i = 8'h01;
        tick(); tick();
        rd(4'd8);
        vectors++; if (rd_data !== 32'h01) begin miscompares++; $display("FAIL stat_pre_fall: got %h want 01", rd_data); end
        rd(4'd8);
        vectors++; if (rd_data !== 32'h03) begin miscompares++; $display("FAIL stat_fall: got %h want 03", rd_data); end
        wr(4'd8, 32'h01);
        rd(4'd8);
        vectors++; if (rd_data !== 32'h02) begin miscompares++; $display("FAIL w1c_0: got %h want 02", rd_data); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_hold: got %b want 1", irq); end
        wr(4'd8, 32'h02);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b want 0", irq); end
    endtask

    task automatic test_collision();
        gpio_i = 8'h00;
        repeat (4) tick();
        gpio_i = 8'h01;
        tick(); tick();
        wr(4'd8, 32'h01);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL w1c_collide_irq: got %b want 1", irq); end
        rd(4'd8);
        vectors++; if (rd_data !== 32'h01) begin miscompares++; $display("FAIL w1c_collide: got %h want 01", rd_data); end
        wr(4'd8, 32'h01);
        addr = 4'd0; wr_data = 32'h5A; we = 1; re = 1;
        tick();
        we = 0; re = 0;
        vectors++; if (rd_data !== 32'hC3) begin miscompares++; $display("FAIL rw_old: got %h want c3", rd_data); end
        vectors++; if (gpio_o !== 8'h5A) begin miscompares++; $display("FAIL rw_new: got %h want 5a", gpio_o); end
    endtask

    task automatic test_unmapped();
        wr(4'd12, 32'hFF);
        wr(4'd2, 32'h00);
        vectors++; if (gpio_o !== 8'h5A || gpio_oe !== 8'hFF) begin miscompares++; $display("FAIL unmapped_wr: got %h/%h want 5a/ff", gpio_o, gpio_oe); end
        rd(4'd12);
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL unmapped_rd: got %h want 0", rd_data); end
    endtask

    task automatic test_width4();
        addr4 = 4'd0; wd4 = 32'hFFFF_FFFF; we4 = 1;
        tick();
        we4 = 0;
        vectors++; if (o4 !== 4'hF) begin miscompares++; $display("FAIL w4_out: got %h want f", o4); end
        re4 = 1;
        tick();
        re4 = 0;
        vectors++; if (rd4 !== 32'h0000_000F) begin miscompares++; $display("FAIL w4_read: got %h want 0000000f", rd4); end
        addr4 = 4'd12; wd4 = 32'h0; we4 = 1;
        tick();
        we4 = 0;
        vectors++; if (o4 !== 4'hF || oe4 !== 4'hF) begin miscompares++; $display("FAIL w4_unmapped_wr: got %h/%h want f/f", o4, oe4); end
        re4 = 1;
        tick();
        re4 = 0;
        vectors++; if (rd4 !== 32'h0) begin miscompares++; $display("FAIL w4_unmapped_rd: got %h want 0", rd4); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 149) == 0);
            we      = ($urandom_range(0, 2) == 0);
            re      = $urandom_range(0, 1);
            addr    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            wr_data = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_i = 8'($urandom);
            tick();
            vectors++; if (rd_data !== m_rd) begin miscompares++; $display("FAIL rnd_rd[%0d]: got %h want %h", n, rd_data, m_rd); end
            vectors++; if (gpio_o !== m_out) begin miscompares++; $display("FAIL rnd_out[%0d]: got %h want %h", n, gpio_o, m_out); end
            vectors++; if (gpio_oe !== m_dir) begin miscompares++; $display("FAIL rnd_dir[%0d]: got %h want %h", n, gpio_oe, m_dir); end
            vectors++; if (irq !== (m_stat != 0)) begin miscompares++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq, m_stat != 0); end
        end
        rst = 0; we = 0; re = 0;
    endtask

    initial begin
        test_reset();
        test_atomic();
        test_input_latency();
        test_edge_irq();
        test_collision();
        test_unmapped();
        test_width4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
